// File: rtl/accel_sampler.sv
// accel_sampler: runs the accelerometer register-write init, then issues periodic
// burst reads, assembles signed little-endian samples and box-car averages them.
module accel_sampler #(
  parameter int         SAMPLE_PERIOD  = 1000000,
  parameter int         NUM_AXES       = 3,
  parameter int         AVG_LOG2       = 0,
  parameter logic [7:0] FORMAT_DATA    = 8'h0B,
  parameter logic [7:0] POWER_DATA     = 8'h08,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  output logic        spi_start,
  output logic [5:0]  spi_addr,
  output logic        spi_rw,
  output logic        spi_mb,
  output logic [2:0]  spi_len,
  output logic [7:0]  spi_wdata,
  input  logic [7:0]  spi_rdata,
  input  logic        spi_done,
  input  logic        spi_busy,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] z,
  output logic        sample_valid,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        clr_status
);

  localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int ACC_W  = 16 + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam logic [2:0]       BURST_LEN = 3'(2 * NUM_AXES);
  localparam logic [CNT_W-1:0] AVG_N     = CNT_W'(1 << AVG_LOG2);

  typedef enum logic [2:0] {INIT_FMT, INIT_PWR, WAIT_TICK, READ, ACCUM, EMIT} state_t;

  state_t state_q, state_d;
  logic txn_q, txn_d;
  logic busy_prev_q;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic [2:0][15:0] raw_q, raw_d;
  logic signed [ACC_W-1:0] acc_q [3];
  logic signed [ACC_W-1:0] acc_d [3];
  logic [CNT_W-1:0] avg_cnt_q, avg_cnt_d;
  logic [2:0][15:0] out_q, out_d;
  logic sample_valid_q, sample_valid_d;
  logic overrun_q, overrun_d;
  logic timeout_err_q, timeout_err_d;
  logic spi_start_q, spi_start_d;
  logic [5:0] spi_addr_q, spi_addr_d;
  logic spi_rw_q, spi_rw_d;
  logic spi_mb_q, spi_mb_d;
  logic [2:0] spi_len_q, spi_len_d;
  logic [7:0] spi_wdata_q, spi_wdata_d;
  logic tick, busy_fell, timed_out;

  // Next-state, transaction control, byte assembly, accumulation and status flags.
  always_comb begin
    state_d        = state_q;
    txn_d          = txn_q;
    byte_idx_d     = byte_idx_q;
    raw_d          = raw_q;
    avg_cnt_d      = avg_cnt_q;
    out_d          = out_q;
    sample_valid_d = 1'b0;
    spi_start_d    = 1'b0;
    spi_addr_d     = spi_addr_q;
    spi_rw_d       = spi_rw_q;
    spi_mb_d       = spi_mb_q;
    spi_len_d      = spi_len_q;
    spi_wdata_d    = spi_wdata_q;
    for (int i = 0; i < 3; i++) acc_d[i] = acc_q[i];

    tick       = (tick_cnt_q == TICK_W'(SAMPLE_PERIOD - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    busy_fell  = txn_q && busy_prev_q && !spi_busy;
    timed_out  = txn_q && !busy_fell && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    to_cnt_d   = txn_q ? to_cnt_q + 1'b1 : to_cnt_q;

    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    if (clr_status) begin
      overrun_d     = 1'b0;
      timeout_err_d = 1'b0;
    end
    if (tick && state_q != WAIT_TICK) overrun_d = 1'b1;
    if (timed_out) timeout_err_d = 1'b1;

    case (state_q)
      INIT_FMT, INIT_PWR: begin
        if (!txn_q) begin
          spi_start_d = 1'b1;
          txn_d       = 1'b1;
          to_cnt_d    = '0;
          spi_addr_d  = (state_q == INIT_FMT) ? 6'h31 : 6'h2D;
          spi_wdata_d = (state_q == INIT_FMT) ? FORMAT_DATA : POWER_DATA;
          spi_rw_d    = 1'b0;
          spi_mb_d    = 1'b0;
          spi_len_d   = 3'd1;
        end else if (busy_fell) begin
          txn_d   = 1'b0;
          state_d = (state_q == INIT_FMT) ? INIT_PWR : WAIT_TICK;
        end else if (timed_out) begin
          txn_d = 1'b0;
        end
      end
      WAIT_TICK: begin
        if (tick) begin
          spi_start_d = 1'b1;
          txn_d       = 1'b1;
          to_cnt_d    = '0;
          byte_idx_d  = '0;
          spi_addr_d  = 6'h32;
          spi_rw_d    = 1'b1;
          spi_mb_d    = 1'b1;
          spi_len_d   = BURST_LEN;
          state_d     = READ;
        end
      end
      READ: begin
        if (spi_done && byte_idx_q < BURST_LEN) begin
          if (byte_idx_q[0]) raw_d[byte_idx_q[2:1]][15:8] = spi_rdata;
          else               raw_d[byte_idx_q[2:1]][7:0]  = spi_rdata;
          byte_idx_d = byte_idx_q + 3'd1;
        end
        if (busy_fell) begin
          txn_d   = 1'b0;
          state_d = (byte_idx_d == BURST_LEN) ? ACCUM : WAIT_TICK;
        end else if (timed_out) begin
          txn_d   = 1'b0;
          state_d = WAIT_TICK;
        end
      end
      ACCUM: begin
        for (int i = 0; i < 3; i++) acc_d[i] = acc_q[i] + ACC_W'($signed(raw_q[i]));
        avg_cnt_d = avg_cnt_q + 1'b1;
        if (avg_cnt_d == AVG_N) begin
          for (int i = 0; i < 3; i++) out_d[i] = 16'(acc_d[i] >>> AVG_LOG2);
          sample_valid_d = 1'b1;
          state_d        = EMIT;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      EMIT: begin
        for (int i = 0; i < 3; i++) acc_d[i] = '0;
        avg_cnt_d = '0;
        state_d   = WAIT_TICK;
      end
      default: state_d = INIT_FMT;
    endcase
  end

  // State and datapath registers; reset re-runs the init sequence from scratch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= INIT_FMT;
      txn_q          <= 1'b0;
      busy_prev_q    <= 1'b0;
      tick_cnt_q     <= '0;
      to_cnt_q       <= '0;
      byte_idx_q     <= '0;
      raw_q          <= '0;
      avg_cnt_q      <= '0;
      out_q          <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
      spi_start_q    <= 1'b0;
      spi_addr_q     <= 6'h31;
      spi_rw_q       <= 1'b0;
      spi_mb_q       <= 1'b0;
      spi_len_q      <= 3'd1;
      spi_wdata_q    <= FORMAT_DATA;
      for (int i = 0; i < 3; i++) acc_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      txn_q          <= txn_d;
      busy_prev_q    <= spi_busy;
      tick_cnt_q     <= tick_cnt_d;
      to_cnt_q       <= to_cnt_d;
      byte_idx_q     <= byte_idx_d;
      raw_q          <= raw_d;
      avg_cnt_q      <= avg_cnt_d;
      out_q          <= out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
      spi_start_q    <= spi_start_d;
      spi_addr_q     <= spi_addr_d;
      spi_rw_q       <= spi_rw_d;
      spi_mb_q       <= spi_mb_d;
      spi_len_q      <= spi_len_d;
      spi_wdata_q    <= spi_wdata_d;
      for (int i = 0; i < 3; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign spi_start    = spi_start_q;
  assign spi_addr     = spi_addr_q;
  assign spi_rw       = spi_rw_q;
  assign spi_mb       = spi_mb_q;
  assign spi_len      = spi_len_q;
  assign spi_wdata    = spi_wdata_q;
  assign x            = out_q[0];
  assign y            = out_q[1];
  assign z            = out_q[2];
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_accel_sampler.sv
// tb_accel_sampler: three lockstep sampler instances (plain, 4x averaging,
// single axis) served by one bench SPI model that answers instance A.
module tb_accel_sampler;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] spi_rdata;
  logic spi_done, spi_busy, clr_status;

  logic start_a, rw_a, mb_a, sv_a, ovr_a, to_a;
  logic [5:0] addr_a;
  logic [2:0] len_a;
  logic [7:0] wdata_a;
  logic [15:0] x_a, y_a, z_a;

  logic start_b, rw_b, mb_b, sv_b, ovr_b, to_b;
  logic [5:0] addr_b;
  logic [2:0] len_b;
  logic [7:0] wdata_b;
  logic [15:0] x_b, y_b, z_b;

  logic start_c, rw_c, mb_c, sv_c, ovr_c, to_c;
  logic [5:0] addr_c;
  logic [2:0] len_c;
  logic [7:0] wdata_c;
  logic [15:0] x_c, y_c, z_c;

  typedef struct {
    logic [47:0] bytes;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [15:0] ez;
  } vec_t;

  vec_t vecs [8];
  logic [47:0] qA[$];
  logic [47:0] qB[$];
  logic [47:0] qC[$];
  int checks = 0;
  int errors = 0;
  int sumX = 0, sumY = 0, sumZ = 0, avgCnt = 0;

  accel_sampler #(.SAMPLE_PERIOD(100), .NUM_AXES(3), .AVG_LOG2(0), .FORMAT_DATA(8'h0B),
                  .POWER_DATA(8'h08), .TIMEOUT_CYCLES(200)) dutA (
    .clk(clk), .rst(rst), .spi_start(start_a), .spi_addr(addr_a), .spi_rw(rw_a),
    .spi_mb(mb_a), .spi_len(len_a), .spi_wdata(wdata_a), .spi_rdata(spi_rdata),
    .spi_done(spi_done), .spi_busy(spi_busy), .x(x_a), .y(y_a), .z(z_a),
    .sample_valid(sv_a), .overrun(ovr_a), .timeout_err(to_a), .clr_status(clr_status));

  accel_sampler #(.SAMPLE_PERIOD(100), .NUM_AXES(3), .AVG_LOG2(2), .FORMAT_DATA(8'h0B),
                  .POWER_DATA(8'h08), .TIMEOUT_CYCLES(200)) dutB (
    .clk(clk), .rst(rst), .spi_start(start_b), .spi_addr(addr_b), .spi_rw(rw_b),
    .spi_mb(mb_b), .spi_len(len_b), .spi_wdata(wdata_b), .spi_rdata(spi_rdata),
    .spi_done(spi_done), .spi_busy(spi_busy), .x(x_b), .y(y_b), .z(z_b),
    .sample_valid(sv_b), .overrun(ovr_b), .timeout_err(to_b), .clr_status(clr_status));

  accel_sampler #(.SAMPLE_PERIOD(100), .NUM_AXES(1), .AVG_LOG2(0), .FORMAT_DATA(8'h0B),
                  .POWER_DATA(8'h08), .TIMEOUT_CYCLES(200)) dutC (
    .clk(clk), .rst(rst), .spi_start(start_c), .spi_addr(addr_c), .spi_rw(rw_c),
    .spi_mb(mb_c), .spi_len(len_c), .spi_wdata(wdata_c), .spi_rdata(spi_rdata),
    .spi_done(spi_done), .spi_busy(spi_busy), .x(x_c), .y(y_c), .z(z_c),
    .sample_valid(sv_c), .overrun(ovr_c), .timeout_err(to_c), .clr_status(clr_status));

  // 100 MHz-style bench clock; the period value itself is irrelevant to the design.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Scoreboard push: A and C get one result per full read, B one per four reads.
  task automatic pushExpect(input vec_t v);
    qA.push_back({v.ez, v.ey, v.ex});
    qC.push_back({16'h0000, 16'h0000, v.ex});
    sumX += int'($signed(v.ex));
    sumY += int'($signed(v.ey));
    sumZ += int'($signed(v.ez));
    avgCnt++;
    if (avgCnt == 4) begin
      qB.push_back({16'(sumZ >>> 2), 16'(sumY >>> 2), 16'(sumX >>> 2)});
      sumX = 0; sumY = 0; sumZ = 0; avgCnt = 0;
    end
  endtask

  // SPI slave model: busy, nbytes done pulses, optional extra busy time, busy falls.
  task automatic applyStimulus(input logic [47:0] data, input int nbytes, input int extraBusy);
    @(posedge clk); #1 spi_busy = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk); #1 spi_rdata = data[8*i +: 8]; spi_done = 1'b1;
      @(posedge clk); #1 spi_done = 1'b0;
    end
    repeat (extraBusy) @(posedge clk);
    @(posedge clk); #1 spi_busy = 1'b0;
  endtask

  task automatic waitStart(input string name, input logic [5:0] eaddr, input logic erw,
                           input logic [7:0] ewdata, input logic [2:0] elen);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (start_a) seen = 1'b1;
    end
    checkOutput({name, "_start_seen"}, seen, 1);
    if (seen) begin
      checkOutput({name, "_addr"}, addr_a, eaddr);
      checkOutput({name, "_rw"}, rw_a, erw);
      checkOutput({name, "_mb"}, mb_a, erw);
      checkOutput({name, "_len"}, len_a, elen);
      if (!erw) checkOutput({name, "_wdata"}, wdata_a, ewdata);
    end
  endtask

  // Called right after busy falls: strobe must appear exactly two cycles later.
  task automatic checkValidTiming();
    @(negedge clk); checkOutput("valid_c0", sv_a, 0);
    @(negedge clk); checkOutput("valid_c1", sv_a, 0);
    @(negedge clk); checkOutput("valid_c2", sv_a, 1);
    @(negedge clk); checkOutput("valid_c3", sv_a, 0);
  endtask

  task automatic serveInit();
    applyStimulus(48'h0, 1, 0);
    waitStart("init_pwr", 6'h2D, 1'b0, 8'h08, 3'd1);
    applyStimulus(48'h0, 1, 0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_xyz"}, {x_a, y_a, z_a}, 48'h0);
    checkOutput({name, "_valid"}, sv_a, 0);
    checkOutput({name, "_overrun"}, ovr_a, 0);
    checkOutput({name, "_timeout"}, to_a, 0);
    checkOutput({name, "_start"}, start_a, 0);
    checkOutput({name, "_spi_regs"}, {addr_a, rw_a, mb_a, len_a, wdata_a}, {6'h31, 1'b0, 1'b0, 3'd1, 8'h0B});
  endtask

  // Scoreboard monitor: every strobe pops and compares one expected result.
  always @(negedge clk) begin
    if (sv_a) begin
      checkOutput("a_expect_pending", (qA.size() > 0), 1);
      if (qA.size() > 0) checkOutput("a_sample", {z_a, y_a, x_a}, qA.pop_front());
    end
    if (sv_b) begin
      checkOutput("b_expect_pending", (qB.size() > 0), 1);
      if (qB.size() > 0) checkOutput("b_sample", {z_b, y_b, x_b}, qB.pop_front());
    end
    if (sv_c) begin
      checkOutput("c_expect_pending", (qC.size() > 0), 1);
      if (qC.size() > 0) checkOutput("c_sample", {z_c, y_c, x_c}, qC.pop_front());
    end
  end

  initial begin
    int starts;
    logic seen;
    vecs[0] = '{48'h8000_1234_0004, 16'h0004, 16'h1234, 16'h8000};
    vecs[1] = '{48'h0001_7FFF_0005, 16'h0005, 16'h7FFF, 16'h0001};
    vecs[2] = '{48'hFFFF_0000_FFFD, 16'hFFFD, 16'h0000, 16'hFFFF};
    vecs[3] = '{48'h0080_2010_FFF9, 16'hFFF9, 16'h2010, 16'h0080};
    vecs[4] = '{48'h8000_ABCD_1234, 16'h1234, 16'hABCD, 16'h8000};
    vecs[5] = '{48'h8000_8000_8000, 16'h8000, 16'h8000, 16'h8000};
    vecs[6] = '{48'h7FFF_7FFF_7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[7] = '{48'h0003_0002_0001, 16'h0001, 16'h0002, 16'h0003};

    rst = 1'b1; spi_rdata = 8'h00; spi_done = 1'b0; spi_busy = 1'b0; clr_status = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");

    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("first_start", start_a, 1);
    checkOutput("init_fmt_regs", {addr_a, rw_a, mb_a, len_a, wdata_a}, {6'h31, 1'b0, 1'b0, 3'd1, 8'h0B});
    serveInit();

    for (int i = 0; i < 8; i++) begin
      waitStart("read", 6'h32, 1'b1, 8'h00, 3'd6);
      checkOutput("c_len", len_c, 3'd2);
      if (i > 0) checkOutput("x_hold", x_a, vecs[i-1].ex);
      pushExpect(vecs[i]);
      applyStimulus(vecs[i].bytes, 6, 0);
      checkValidTiming();
    end

    // Short burst: a single byte then busy falls, so nothing is accumulated.
    waitStart("short", 6'h32, 1'b1, 8'h00, 3'd6);
    applyStimulus(vecs[0].bytes, 1, 0);
    repeat (6) @(negedge clk);
    checkOutput("short_hold", {z_a, y_a, x_a}, {vecs[7].ez, vecs[7].ey, vecs[7].ex});

    // Overrun: busy held across a tick; the dropped tick must not start a read later.
    checkOutput("overrun_pre", ovr_a, 0);
    waitStart("ovr_read", 6'h32, 1'b1, 8'h00, 3'd6);
    pushExpect(vecs[5]);
    applyStimulus(vecs[5].bytes, 6, 150);
    checkValidTiming();
    starts = 0;
    repeat (16) begin
      @(negedge clk);
      if (start_a) starts++;
    end
    checkOutput("no_queued_read", starts, 0);
    checkOutput("overrun_set", ovr_a, 1);
    @(posedge clk); #1 clr_status = 1'b1;
    @(posedge clk); #1 clr_status = 1'b0;
    @(negedge clk);
    checkOutput("overrun_clr", ovr_a, 0);

    // Timeout: busy stuck high with no bytes until the sequencer gives up.
    waitStart("to_read", 6'h32, 1'b1, 8'h00, 3'd6);
    @(posedge clk); #1 spi_busy = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (to_a) seen = 1'b1;
    end
    checkOutput("timeout_set", seen, 1);
    @(posedge clk); #1 spi_busy = 1'b0;
    waitStart("post_to_read", 6'h32, 1'b1, 8'h00, 3'd6);
    checkOutput("timeout_sticky", to_a, 1);
    pushExpect(vecs[7]);
    applyStimulus(vecs[7].bytes, 6, 0);
    checkValidTiming();
    @(posedge clk); #1 clr_status = 1'b1;
    @(posedge clk); #1 clr_status = 1'b0;
    @(negedge clk);
    checkOutput("timeout_clr", to_a, 0);

    // Reset in the middle of a burst: outputs clear and init runs again.
    waitStart("abort_read", 6'h32, 1'b1, 8'h00, 3'd6);
    @(posedge clk); #1 spi_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 spi_rdata = 8'hA5; spi_done = 1'b1;
      @(posedge clk); #1 spi_done = 1'b0;
    end
    @(posedge clk); #1 rst = 1'b1; spi_busy = 1'b0; spi_done = 1'b0;
    sumX = 0; sumY = 0; sumZ = 0; avgCnt = 0;
    @(posedge clk);
    @(negedge clk);
    checkResetState("midreset");
    @(posedge clk); #1 rst = 1'b0;
    waitStart("reinit_fmt", 6'h31, 1'b0, 8'h0B, 3'd1);
    serveInit();
    waitStart("reinit_read", 6'h32, 1'b1, 8'h00, 3'd6);
    pushExpect(vecs[4]);
    applyStimulus(vecs[4].bytes, 6, 0);
    checkValidTiming();

    repeat (10) @(negedge clk);
    checkOutput("qA_drained", qA.size(), 0);
    checkOutput("qB_drained", qB.size(), 0);
    checkOutput("qC_drained", qC.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_sampler.md
# accel_sampler

Parametrised sequencer between the board accelerometer SPI master and the attitude datapath. After reset it runs a configurable register-write init sequence, then issues periodic multi-byte burst reads of 1–3 axes. It assembles signed little-endian samples, optionally box-car averages 2^AVG_LOG2 reads per output, and presents results with a one-cycle valid strobe. It adds overrun and SPI-timeout status flags.

## Interface

- SAMPLE_PERIOD, 1000000: clk cycles between read triggers; minimum 16.
- NUM_AXES, 3: axes read per burst, 1–3; burst length is 2*NUM_AXES bytes from 0x32.
- AVG_LOG2, 0: each output averages 2^AVG_LOG2 reads; 0–4.
- FORMAT_DATA, 8'h0B: written to DATA_FORMAT (0x31) during init.
- POWER_DATA, 8'h08: written to POWER_CTL (0x2D) during init.
- TIMEOUT_CYCLES, 4096: maximum cycles from spi_start to spi_busy falling.
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- spi_start  out  1  one-cycle transaction start pulse to SPI master
- spi_addr  out  6  register address
- spi_rw  out  1  1 = read, 0 = write
- spi_mb  out  1  multi-byte (burst) enable
- spi_len  out  3  bytes in transaction, 1–6
- spi_wdata  out  8  write data
- spi_rdata  in  8  received byte, valid while spi_done=1
- spi_done  in  1  one-cycle pulse per completed byte
- spi_busy  in  1  high while CS asserted
- x, y, z  out  16 each  signed averaged samples; unread axes held at 0
- sample_valid  out  1  one-cycle pulse when x/y/z update
- overrun  out  1  sticky: trigger arrived while a read was in progress
- timeout_err  out  1  sticky: SPI transaction exceeded TIMEOUT_CYCLES
- clr_status  in  1  clears overrun and timeout_err

## Operation

- States: INIT_FMT, INIT_PWR, WAIT_TICK, READ, ACCUM, EMIT.
- rst → INIT_FMT. Write FORMAT_DATA to 0x31 (spi_rw=0, spi_mb=0, spi_len=1).
- INIT_FMT → INIT_PWR once spi_busy falls. INIT_PWR writes POWER_DATA to 0x2D, then → WAIT_TICK.
- Tick counter runs free from reset, 0..SAMPLE_PERIOD-1. The tick pulse fires at the wrap.
- WAIT_TICK + tick → READ: spi_start with addr 0x32, rw=1, mb=1, len=2*NUM_AXES.
- READ counts spi_done pulses (byte index 0..len-1).
  - Even index → low byte of axis index/2.
  - Odd index → high byte.
  - When spi_busy falls after all len bytes → ACCUM.
- ACCUM: sign-extend each 16-bit raw axis and add it to its accumulator. Accumulators are signed, 16+AVG_LOG2 bits wide, wrap-free by construction.
  - Increment avg_cnt.
  - If avg_cnt reaches 2^AVG_LOG2 → EMIT, else → WAIT_TICK.
- EMIT: outputs = accumulator >>> AVG_LOG2 (arithmetic shift, floor). Pulse sample_valid. Zero accumulators and avg_cnt. → WAIT_TICK.
- Short burst: spi_busy falls with fewer than len spi_done pulses. The read is discarded: no accumulate, → WAIT_TICK, no flag.
- Tick outside WAIT_TICK (including during init): set overrun and drop that tick. The pending read is not queued.
- Timeout counter restarts at every spi_start. On reaching TIMEOUT_CYCLES while a transaction is outstanding:
  - Set timeout_err.
  - Discard partial data.
  - Init states retry the same write; READ → WAIT_TICK.
- clr_status and a same-cycle set event: the set wins.

## Timing

- Reset values: x=y=z=0, sample_valid=0, overrun=0, timeout_err=0, spi_start=0, spi_len=1, spi_addr=0x31, spi_rw=0, spi_mb=0, spi_wdata=FORMAT_DATA, all counters 0.
- The first spi_start is asserted on the first cycle after rst deasserts.
- spi_addr, spi_rw, spi_mb, spi_len, spi_wdata are registered, stable from the spi_start cycle until spi_busy falls.
- Tick in WAIT_TICK → spi_start on the next cycle.
- spi_busy falling edge → ACCUM next cycle.
- With AVG_LOG2=0, EMIT follows ACCUM, and sample_valid is 2 cycles after spi_busy falls.
- x/y/z change only in the sample_valid cycle and hold otherwise.
- rst mid-transaction aborts immediately: spi_start is low, partial data is lost, and init is re-run. The SPI master is reset by the same rst.

## Test plan

- Init: bench SPI model, release rst → write 0x0B to 0x31, then 0x08 to 0x2D, single-byte; no read before the second write completes.
- Burst read, SAMPLE_PERIOD=100, NUM_AXES=3, AVG_LOG2=0, bytes 34 12 CD AB 00 80 → x=0x1234, y=0xABCD, z=0x8000, a single sample_valid pulse 2 cycles after busy falls.
- Averaging, AVG_LOG2=2, x raw = 4, 5, -3, -7 → after the 4th read x=0xFFFF (-1, floor), sample_valid once per 4 reads.
- NUM_AXES=1 → spi_len=2, y=z=0 always.
- Overrun: the SPI model holds busy for 150 cycles with SAMPLE_PERIOD=100 → overrun=1; clr_status clears it; no queued read.
- Timeout and mid-read reset: busy stuck high for TIMEOUT_CYCLES → timeout_err=1, return to WAIT_TICK. Separately, rst asserted mid-burst → outputs 0 and the init sequence repeats.
